// File: rtl/fpu_issue_ctrl.sv
// Issue/response sequencer between EX and a multi-cycle FPU: pulses start, stalls the
// pipeline until done, holds the result for writeback, drains flushed ops and flags timeouts.
module fpu_issue_ctrl #(
  parameter int DATA_W         = 32,
  parameter int OP_W           = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid_ex,
  input  logic              i_is_fp_multi,
  input  logic [OP_W-1:0]   i_alu_op,
  input  logic              i_flush,
  input  logic              i_fpu_done,
  input  logic [DATA_W-1:0] i_fpu_data,
  input  logic              i_wb_ready,
  output logic              o_fpu_start,
  output logic [OP_W-1:0]   o_fpu_op,
  output logic              o_stall,
  output logic [DATA_W-1:0] o_result,
  output logic              o_result_valid,
  output logic              o_timeout
);

  // One spare count value so a flush on the last WAIT cycle cannot wrap the counter in DRAIN.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             issue;
  logic             expired;

  assign issue   = i_valid_ex & i_is_fp_multi & ~i_flush;
  assign expired = (cnt_reg >= CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (issue) state_next = S_START;
      S_START: state_next = i_flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        // A flush landing on the done cycle has nothing left to drain.
        if (i_flush)                state_next = i_fpu_done ? S_IDLE : S_DRAIN;
        else if (i_fpu_done || expired) state_next = S_RESP;
      end
      S_RESP:  if (i_flush || i_wb_ready) state_next = S_IDLE;
      S_DRAIN: if (i_fpu_done || expired) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_fpu_start    = 1'b0;
    o_stall        = 1'b0;
    o_result_valid = 1'b0;
    case (state_reg)
      S_IDLE:  o_stall = issue;
      S_START: begin
        o_fpu_start = 1'b1;
        o_stall     = 1'b1;
      end
      S_WAIT:  o_stall = 1'b1;
      S_RESP: begin
        o_result_valid = 1'b1;
        o_stall        = ~i_wb_ready & ~i_flush;
      end
      // Only hold back another FP op; the FPU is still busy with the flushed one.
      S_DRAIN: o_stall = i_valid_ex & i_is_fp_multi;
      default: o_stall = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg   <= '0;
      o_fpu_op  <= '0;
      o_result  <= '0;
      o_timeout <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE:  if (issue) o_fpu_op <= i_alu_op;
        S_START: cnt_reg <= '0;
        S_WAIT: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (!i_flush) begin
            if (i_fpu_done) begin
              o_result <= i_fpu_data;
            end else if (expired) begin
              o_timeout <= 1'b1;
              o_result  <= '0;
            end
          end
        end
        S_DRAIN: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (!i_fpu_done && expired) o_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: linear cycle-by-cycle stimulus, hand-computed expectations.
module tb_fpu_issue_ctrl;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;
  localparam int TMO    = 8;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_valid_ex;
  logic              i_is_fp_multi;
  logic [OP_W-1:0]   i_alu_op;
  logic              i_flush;
  logic              i_fpu_done;
  logic [DATA_W-1:0] i_fpu_data;
  logic              i_wb_ready;
  logic              o_fpu_start;
  logic [OP_W-1:0]   o_fpu_op;
  logic              o_stall;
  logic [DATA_W-1:0] o_result;
  logic              o_result_valid;
  logic              o_timeout;

  int n_total = 0;
  int n_pass  = 0;

  fpu_issue_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid_ex     (i_valid_ex),
    .i_is_fp_multi  (i_is_fp_multi),
    .i_alu_op       (i_alu_op),
    .i_flush        (i_flush),
    .i_fpu_done     (i_fpu_done),
    .i_fpu_data     (i_fpu_data),
    .i_wb_ready     (i_wb_ready),
    .o_fpu_start    (o_fpu_start),
    .o_fpu_op       (o_fpu_op),
    .o_stall        (o_stall),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .o_timeout      (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Start a new cycle just after the rising edge; inputs are driven here.
  task automatic next_cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic ex_fp(input logic v, input logic [OP_W-1:0] op);
    i_valid_ex    = v;
    i_is_fp_multi = v;
    i_alu_op      = op;
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid_ex = 1'b0; i_is_fp_multi = 1'b0; i_alu_op = '0;
    i_flush = 1'b0; i_fpu_done = 1'b0; i_fpu_data = '0; i_wb_ready = 1'b1;
    #1;
    chk("por_stall", o_stall, 0);
    chk("por_start", o_fpu_start, 0);
    chk("por_rv", o_result_valid, 0);
    chk("por_result", o_result, 0);
    chk("por_timeout", o_timeout, 0);
    next_cyc(); next_cyc();
    i_rst_n = 1'b1;

    // Basic op: EX at c0, done at c4, retire at c5
    next_cyc(); ex_fp(1, 5'h0A); settle();
    chk("t2_c0_stall", o_stall, 1);
    chk("t2_c0_start", o_fpu_start, 0);
    next_cyc(); settle();
    chk("t2_c1_start", o_fpu_start, 1);
    chk("t2_c1_stall", o_stall, 1);
    chk("t2_c1_op", o_fpu_op, 5'h0A);
    next_cyc(); settle();
    chk("t2_c2_start", o_fpu_start, 0);
    chk("t2_c2_stall", o_stall, 1);
    next_cyc(); settle();
    chk("t2_c3_stall", o_stall, 1);
    next_cyc(); i_fpu_done = 1; i_fpu_data = 32'h3F80_0000; settle();
    chk("t2_c4_stall", o_stall, 1);
    chk("t2_c4_rv", o_result_valid, 0);
    next_cyc(); i_fpu_done = 0; i_fpu_data = '0; settle();
    chk("t2_c5_rv", o_result_valid, 1);
    chk("t2_c5_result", o_result, 32'h3F80_0000);
    chk("t2_c5_stall", o_stall, 0);
    chk("t2_c5_start", o_fpu_start, 0);
    next_cyc(); ex_fp(0, 5'h00); settle();
    chk("t2_c6_rv", o_result_valid, 0);
    chk("t2_c6_hold", o_result, 32'h3F80_0000);

    // Writeback backpressure: wb_ready low for 3 RESP cycles
    next_cyc(); ex_fp(1, 5'h0B); i_wb_ready = 0; settle();
    next_cyc(); settle();
    chk("t3_c1_start", o_fpu_start, 1);
    next_cyc(); next_cyc();
    next_cyc(); i_fpu_done = 1; i_fpu_data = 32'h4000_0000;
    next_cyc(); i_fpu_done = 0; i_fpu_data = '0;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) next_cyc();
      settle();
      chk($sformatf("t3_hold%0d_stall", k), o_stall, 1);
      chk($sformatf("t3_hold%0d_rv", k), o_result_valid, 1);
      chk($sformatf("t3_hold%0d_result", k), o_result, 32'h4000_0000);
    end
    next_cyc(); i_wb_ready = 1; settle();
    chk("t3_rel_stall", o_stall, 0);
    chk("t3_rel_rv", o_result_valid, 1);
    next_cyc(); ex_fp(0, 5'h00); settle();
    chk("t3_after_rv", o_result_valid, 0);

    // Flush in WAIT, drain, new op waits until the old op finishes
    next_cyc(); ex_fp(1, 5'h0C); settle();
    next_cyc(); settle();
    chk("t4_c1_start", o_fpu_start, 1);
    next_cyc(); i_flush = 1; ex_fp(0, 5'h00); settle();
    chk("t4_c2_stall", o_stall, 1);
    next_cyc(); i_flush = 0; i_valid_ex = 1; i_is_fp_multi = 0; settle();
    chk("t4_c3_nonfp_stall", o_stall, 0);
    chk("t4_c3_rv", o_result_valid, 0);
    next_cyc(); ex_fp(1, 5'h0D); settle();
    chk("t4_c4_stall", o_stall, 1);
    chk("t4_c4_start", o_fpu_start, 0);
    next_cyc(); settle();
    chk("t4_c5_stall", o_stall, 1);
    next_cyc(); i_fpu_done = 1; i_fpu_data = 32'hAAAA_5555; settle();
    chk("t4_c6_stall", o_stall, 1);
    chk("t4_c6_rv", o_result_valid, 0);
    next_cyc(); i_fpu_done = 0; settle();
    chk("t4_c7_rv", o_result_valid, 0);
    chk("t4_c7_start", o_fpu_start, 0);
    chk("t4_c7_result", o_result, 32'h4000_0000);
    next_cyc(); settle();
    chk("t4_c8_start", o_fpu_start, 1);
    chk("t4_c8_op", o_fpu_op, 5'h0D);
    next_cyc(); settle();
    next_cyc(); i_fpu_done = 1; i_fpu_data = 32'h1234_5678;
    next_cyc(); i_fpu_done = 0; settle();
    chk("t4_c11_rv", o_result_valid, 1);
    chk("t4_c11_result", o_result, 32'h1234_5678);
    next_cyc(); ex_fp(0, 5'h00);

    // Flush and done in the same WAIT cycle
    next_cyc(); ex_fp(1, 5'h0E); settle();
    next_cyc(); settle();
    chk("t6_c1_start", o_fpu_start, 1);
    next_cyc(); i_flush = 1; i_fpu_done = 1; i_fpu_data = 32'hDEAD_BEEF; ex_fp(0, 5'h00);
    next_cyc(); i_flush = 0; i_fpu_done = 0; settle();
    chk("t6_c3_stall", o_stall, 0);
    chk("t6_c3_rv", o_result_valid, 0);
    chk("t6_c3_result", o_result, 32'h1234_5678);
    next_cyc(); ex_fp(1, 5'h11); settle();
    chk("t6_c4_stall", o_stall, 1);
    next_cyc(); settle();
    chk("t6_c5_start_idle", o_fpu_start, 1);
    next_cyc(); settle();
    next_cyc(); i_fpu_done = 1; i_fpu_data = 32'h0BAD_F00D;
    next_cyc(); i_fpu_done = 0; settle();
    chk("t6_c8_result", o_result, 32'h0BAD_F00D);
    next_cyc(); ex_fp(0, 5'h00);

    // Timeout: START at c1, WAIT c2..c9, RESP at c10
    next_cyc(); ex_fp(1, 5'h0F); settle();
    next_cyc(); settle();
    chk("t5_c1_start", o_fpu_start, 1);
    for (int c = 2; c <= 9; c++) begin
      next_cyc(); settle();
      chk($sformatf("t5_c%0d_stall", c), o_stall, 1);
      chk($sformatf("t5_c%0d_rv", c), o_result_valid, 0);
      chk($sformatf("t5_c%0d_tmo", c), o_timeout, 0);
    end
    next_cyc(); settle();
    chk("t5_c10_tmo", o_timeout, 1);
    chk("t5_c10_rv", o_result_valid, 1);
    chk("t5_c10_result", o_result, 0);
    next_cyc(); ex_fp(0, 5'h00); settle();
    chk("t5_c11_rv", o_result_valid, 0);
    chk("t5_c11_tmo_sticky", o_timeout, 1);
    next_cyc(); next_cyc(); settle();
    chk("t5_later_tmo", o_timeout, 1);

    // Asynchronous reset while in WAIT
    next_cyc(); ex_fp(1, 5'h10);
    next_cyc(); settle();
    chk("t1_c1_start", o_fpu_start, 1);
    next_cyc(); ex_fp(0, 5'h00); i_rst_n = 0; settle();
    chk("t1_rst_stall", o_stall, 0);
    chk("t1_rst_start", o_fpu_start, 0);
    chk("t1_rst_op", o_fpu_op, 0);
    chk("t1_rst_rv", o_result_valid, 0);
    chk("t1_rst_result", o_result, 0);
    chk("t1_rst_tmo", o_timeout, 0);
    next_cyc(); i_rst_n = 1;
    next_cyc(); settle();
    chk("t1_post_stall", o_stall, 0);
    chk("t1_post_start", o_fpu_start, 0);
    chk("t1_post_rv", o_result_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
